// File: rtl/bw_clk_cl_hdr_seq.sv
// ---------------------------------------------------------------------------
// bw_clk_cl_hdr_seq
//   Multi-cluster clock-header sequencer. It walks the per-cluster clock
//   enables towards the requested pattern. Only one enable changes per
//   STAGGER cycles, which limits di/dt when clusters power up or down.
//   Each cluster gets a delayed synchronous reset release and a debug-init
//   that lags that release by one cycle. The enable registers form a scan
//   chain.
//
// Ports
//   gclk            global clock, all state on its rising edge
//   grst            synchronous active-high reset (beats se and all inputs)
//   cken_req        requested enable per cluster
//   grst_req_l      global reset request, active-low
//   gdbginit_l      global debug-init, active-low
//   se, si          scan enable / scan in
//   cluster_cken    registered cluster clock enables
//   cluster_grst_l  registered per-cluster reset, active-low
//   dbginit_l       registered per-cluster debug-init, active-low
//   seq_busy        sequencer holding off, or a request is pending
//   so              scan out (cluster_cken[NCLK-1])
// ---------------------------------------------------------------------------
module bw_clk_cl_hdr_seq #(
    parameter int NCLK    = 4,
    parameter int STAGGER = 4,
    parameter int RST_DLY = 8,
    parameter int CNT_W   = 8
) (
    input  logic            gclk,
    input  logic            grst,
    input  logic [NCLK-1:0] cken_req,
    input  logic            grst_req_l,
    input  logic            gdbginit_l,
    input  logic            se,
    input  logic            si,
    output logic [NCLK-1:0] cluster_cken,
    output logic [NCLK-1:0] cluster_grst_l,
    output logic [NCLK-1:0] dbginit_l,
    output logic            seq_busy,
    output logic            so
);

    localparam int PTR_W = $clog2(NCLK);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] stag_cnt;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] rc [NCLK];

    logic [NCLK-1:0]  mm;
    logic             found;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] ptr_nxt;
    logic [NCLK-1:0]  cken_nxt;
    logic             serve;

    assign mm       = cken_req ^ cluster_cken;
    assign seq_busy = (state == HOLD) | (|mm);
    assign so       = cluster_cken[NCLK-1];
    assign serve    = !se && (state == IDLE) && (|mm);

    // Round-robin pick: first mismatching cluster at or after ptr, wrapping.
    always_comb begin
        logic [PTR_W:0] sum;
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        for (int k = 0; k < NCLK; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NCLK)) begin
                sum = sum - (PTR_W+1)'(NCLK);
            end
            if (!found && mm[sum[PTR_W-1:0]]) begin
                found = 1'b1;
                sel   = sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_nxt = (sel == PTR_W'(NCLK-1)) ? '0 : sel + PTR_W'(1);
    end

    // Enable value this edge will load; the reset counters qualify on it so a
    // cluster's reset asserts on the same edge its enable falls.
    always_comb begin
        cken_nxt = cluster_cken;
        if (se) begin
            cken_nxt = {cluster_cken[NCLK-2:0], si};
        end else if (serve) begin
            cken_nxt[sel] = ~cluster_cken[sel];
        end
    end

    // Stage: sequencer FSM and enable registers
    always_ff @(posedge gclk) begin
        if (grst) begin
            state        <= IDLE;
            stag_cnt     <= '0;
            ptr          <= '0;
            cluster_cken <= '0;
        end else begin
            cluster_cken <= cken_nxt;
            if (!se) begin
                case (state)
                    IDLE: begin
                        if (serve) begin
                            ptr <= ptr_nxt;
                            if (STAGGER > 1) begin
                                stag_cnt <= CNT_W'(STAGGER - 1);
                                state    <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        stag_cnt <= stag_cnt - CNT_W'(1);
                        if (stag_cnt == CNT_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Stage: per-cluster reset delay counters and reset release
    always_ff @(posedge gclk) begin
        if (grst) begin
            for (int i = 0; i < NCLK; i++) begin
                rc[i] <= '0;
            end
            cluster_grst_l <= '0;
        end else if (!se) begin
            for (int i = 0; i < NCLK; i++) begin
                if (!cken_nxt[i] || !grst_req_l) begin
                    rc[i]             <= '0;
                    cluster_grst_l[i] <= 1'b0;
                end else if (rc[i] != CNT_W'(RST_DLY)) begin
                    rc[i] <= rc[i] + CNT_W'(1);
                    if (rc[i] + CNT_W'(1) == CNT_W'(RST_DLY)) begin
                        cluster_grst_l[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Stage: debug-init, one cycle behind the reset release
    always_ff @(posedge gclk) begin
        if (grst) begin
            dbginit_l <= '0;
        end else begin
            dbginit_l <= cluster_grst_l & {NCLK{gdbginit_l}};
        end
    end

endmodule

// File: tb/tb_bw_clk_cl_hdr_seq.sv
module tb_bw_clk_cl_hdr_seq;

    localparam int N = 4;
    localparam int S = 4;
    localparam int R = 8;

    logic         gclk = 1'b0;
    logic         grst;
    logic [N-1:0] cken_req;
    logic         grst_req_l;
    logic         gdbginit_l;
    logic         se;
    logic         si;
    logic [N-1:0] cluster_cken;
    logic [N-1:0] cluster_grst_l;
    logic [N-1:0] dbginit_l;
    logic         seq_busy;
    logic         so;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [N-1:0] m_cken;
    logic [N-1:0] m_grst;
    logic [N-1:0] m_dbg;
    int           m_ptr;
    int           m_cool;   // edges left before the next change is allowed
    int           m_rc [N]; // consecutive qualified edges per cluster

    bw_clk_cl_hdr_seq #(.NCLK(N), .STAGGER(S), .RST_DLY(R), .CNT_W(8)) dut (
        .gclk           (gclk),
        .grst           (grst),
        .cken_req       (cken_req),
        .grst_req_l     (grst_req_l),
        .gdbginit_l     (gdbginit_l),
        .se             (se),
        .si             (si),
        .cluster_cken   (cluster_cken),
        .cluster_grst_l (cluster_grst_l),
        .dbginit_l      (dbginit_l),
        .seq_busy       (seq_busy),
        .so             (so)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] nc;
        logic [N-1:0] mm;
        logic [N-1:0] prev_grst;
        logic         done;
        int           j;
        prev_grst = m_grst;
        if (grst) begin
            m_cken = '0; m_grst = '0; m_dbg = '0;
            m_ptr = 0; m_cool = 0;
            for (int i = 0; i < N; i++) m_rc[i] = 0;
        end else begin
            if (se) begin
                nc = {m_cken[N-2:0], si};
            end else begin
                nc = m_cken;
                mm = cken_req ^ m_cken;
                if (m_cool > 0) begin
                    m_cool--;
                end else if (mm != 0) begin
                    done = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        j = (m_ptr + k) % N;
                        if (!done && mm[j]) begin
                            done   = 1'b1;
                            nc[j]  = ~nc[j];
                            m_ptr  = (j + 1) % N;
                            m_cool = S - 1;
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (!nc[i] || !grst_req_l) m_rc[i] = 0;
                    else if (m_rc[i] < R) m_rc[i]++;
                    m_grst[i] = (m_rc[i] == R);
                end
            end
            m_dbg  = prev_grst & {N{gdbginit_l}};
            m_cken = nc;
        end
    endtask

    task automatic step();
        logic exp_busy;
        @(posedge gclk);
        model_edge();
        #1;
        exp_busy = (m_cool > 0) || ((cken_req ^ m_cken) != 0);
        chk("cken",    32'(cluster_cken),   32'(m_cken));
        chk("grst_l",  32'(cluster_grst_l), 32'(m_grst));
        chk("dbginit", 32'(dbginit_l),      32'(m_dbg));
        chk("so",      32'(so),             32'(m_cken[N-1]));
        chk("busy",    32'(seq_busy),       32'(exp_busy));
    endtask

    task automatic do_reset();
        grst = 1'b1;
        step();
        grst = 1'b0;
    endtask

    initial begin
        int rise [N];
        logic g0 [0:31];
        logic d0 [0:31];
        logic pat [4];
        int first_g, first_d;

        grst = 1'b1; cken_req = '0; grst_req_l = 1'b1; gdbginit_l = 1'b1;
        se = 1'b0; si = 1'b0;
        m_cken = '0; m_grst = '0; m_dbg = '0; m_ptr = 0; m_cool = 0;
        for (int i = 0; i < N; i++) m_rc[i] = 0;

        // Reset values, with se and requests active to show grst wins
        se = 1'b1; si = 1'b1; cken_req = '1;
        step();
        chk("rst_cken",  32'(cluster_cken),   0);
        chk("rst_grst",  32'(cluster_grst_l), 0);
        chk("rst_dbg",   32'(dbginit_l),      0);
        chk("rst_so",    32'(so),             0);
        se = 1'b0; si = 1'b0; cken_req = '0;
        step();
        grst = 1'b0;

        // Staggered power-up of all clusters, reset delay and debug-init lag
        for (int b = 0; b < N; b++) rise[b] = -1;
        cken_req = 4'b1111;
        for (int i = 1; i <= 30; i++) begin
            grst_req_l = (i == 20) ? 1'b0 : 1'b1;
            step();
            for (int b = 0; b < N; b++)
                if (cluster_cken[b] && rise[b] < 0) rise[b] = i;
            g0[i] = cluster_grst_l[0];
            d0[i] = dbginit_l[0];
        end
        grst_req_l = 1'b1;
        chk("rise0", 32'(rise[0]), 1);
        chk("rise1", 32'(rise[1]), 5);
        chk("rise2", 32'(rise[2]), 9);
        chk("rise3", 32'(rise[3]), 13);
        first_g = -1; first_d = -1;
        for (int i = 1; i <= 30; i++) begin
            if (g0[i] && first_g < 0) first_g = i;
            if (d0[i] && first_d < 0) first_d = i;
        end
        chk("grst0_rel",   32'(first_g), 8);
        chk("dbg0_rel",    32'(first_d), 9);
        chk("grst0_at19",  32'(g0[19]), 1);
        chk("grst0_at20",  32'(g0[20]), 0);
        chk("grst0_at27",  32'(g0[27]), 0);
        chk("grst0_at28",  32'(g0[28]), 1);

        // Round-robin wrap
        do_reset();
        cken_req = 4'b1000;
        step();
        chk("rr_s1", 32'(cluster_cken), 32'(4'b1000));
        repeat (3) step();
        cken_req = 4'b1011;
        step();
        chk("rr_s2a", 32'(cluster_cken), 32'(4'b1001));
        repeat (4) step();
        chk("rr_s2b", 32'(cluster_cken), 32'(4'b1011));
        repeat (3) step();
        cken_req = 4'b1010;
        step();
        chk("rr_wrap", 32'(cluster_cken), 32'(4'b1010));

        // Request withdrawn during HOLD never toggles
        cken_req = 4'b1110;
        repeat (2) step();
        cken_req = 4'b1010;
        repeat (8) step();
        chk("withdraw", 32'(cluster_cken), 32'(4'b1010));

        // Scan in the middle of a HOLD window
        cken_req = 4'b1110;
        step();
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        se = 1'b1;
        for (int i = 0; i < 4; i++) begin
            si = pat[i];
            step();
        end
        chk("scan_cken", 32'(cluster_cken), 32'(4'b1011));
        chk("scan_so",   32'(so), 1);
        se = 1'b0; si = 1'b0;
        repeat (10) step();

        // grst in the middle of HOLD, then re-sequencing from bit 0
        do_reset();
        cken_req = 4'b0011;
        step();
        repeat (4) step();
        chk("pre_rst", 32'(cluster_cken), 32'(4'b0011));
        step();
        grst = 1'b1;
        step();
        chk("mid_rst_cken", 32'(cluster_cken),   0);
        chk("mid_rst_grst", 32'(cluster_grst_l), 0);
        chk("mid_rst_dbg",  32'(dbginit_l),      0);
        grst = 1'b0;
        step();
        chk("post_rst", 32'(cluster_cken), 32'(4'b0001));

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) cken_req = N'($urandom);
            grst_req_l = ($urandom_range(0, 31) != 0);
            gdbginit_l = ($urandom_range(0, 15) != 0);
            se         = ($urandom_range(0, 15) == 0);
            si         = 1'($urandom);
            grst       = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
